// File: rtl/instr_prefetch_queue_pkg.sv
// Shared constants and types for the instruction prefetch queue and its FIFO.
// The CPU top imports the same constants so both sides agree on widths and the boot address.
package instr_prefetch_queue_pkg;

  localparam int unsigned PQ_DEPTH      = 4;
  localparam int unsigned PQ_ADDR_W     = 16;
  localparam int unsigned PQ_INSTR_W    = 16;
  localparam logic [15:0] PQ_RESET_ADDR = 16'h0000;

  // Fetch-side control flops: one request in flight, optionally marked for dropping.
  typedef struct packed {
    logic outstanding;
    logic discard;
  } fetch_ctl_t;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO with push/pop/flush, an occupancy count, and a registered head output.
// The head register holds its last value when the FIFO is empty.
module instr_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 32,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [W-1:0]     head_data,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_next
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [W-1:0]     head_q, head_d;
  logic [CNT_W-1:0] remain;
  logic             pop_ok;
  logic             push_ok;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    pop_ok   = pop && (count_q != '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push_ok  = push && ((count_q != CNT_W'(DEPTH)) || pop_ok);
    remain   = count_q - CNT_W'(pop_ok);

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = remain + CNT_W'(push_ok);
      // The new head is either the word being pushed into an otherwise empty
      // FIFO, or an entry already stored in the array.
      if (push_ok && (remain == '0)) begin
        head_d = push_data;
      end else if (remain != '0) begin
        head_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign head_data  = head_q;
  assign count      = count_q;
  assign count_next = count_d;

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue between the SPI program-memory reader and the CPU core.
// Keeps up to DEPTH sequential instruction words ahead of execution; a taken branch flushes and refetches.
module instr_prefetch_queue
  import instr_prefetch_queue_pkg::*;
#(
  parameter int unsigned        DEPTH      = PQ_DEPTH,
  parameter int unsigned        ADDR_W     = PQ_ADDR_W,
  parameter int unsigned        INSTR_W    = PQ_INSTR_W,
  parameter logic [ADDR_W-1:0]  RESET_ADDR = ADDR_W'(PQ_RESET_ADDR)
) (
  input  logic               clk,
  input  logic               rst,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_addr,
  output logic               instr_valid,
  input  logic               advance,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned ENT_W = INSTR_W + ADDR_W;

  // Memory handshake: mem_req rises with mem_addr and both hold steady until the
  // one-cycle mem_ack pulse, which carries mem_rdata for that address. Only one
  // request is ever in flight, and a new one can be raised in the cycle after ack.

  fetch_ctl_t        ctl_q, ctl_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

  logic              ack;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_flush;
  logic [ENT_W-1:0]  fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  fifo_count_next;

  assign ack        = mem_ack && ctl_q.outstanding;
  assign fifo_flush = redirect;
  assign fifo_push  = ack && !ctl_q.discard && !redirect;
  assign fifo_pop   = advance && !redirect;

  instr_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fifo_push),
    .push_data  ({mem_rdata, mem_addr_q}),
    .pop        (fifo_pop),
    .flush      (fifo_flush),
    .head_data  (fifo_head),
    .count      (fifo_count),
    .count_next (fifo_count_next)
  );

  always_comb begin
    ctl_d        = ctl_q;
    fetch_addr_d = fetch_addr_q;
    mem_addr_d   = mem_addr_q;

    if (redirect) begin
      fetch_addr_d = redirect_addr;
    end else if (fifo_push) begin
      fetch_addr_d = fetch_addr_q + ADDR_W'(1);
    end

    // The SPI reader cannot abort, so a redirect with a request still in
    // flight marks its ack for dropping; an ack in the redirect cycle is simply
    // not pushed and leaves nothing to drop later.
    if (redirect) begin
      ctl_d.discard = ctl_q.outstanding && !mem_ack;
    end else if (ack) begin
      ctl_d.discard = 1'b0;
    end

    if (ack) begin
      ctl_d.outstanding = 1'b0;
    end

    // Credit check against next-cycle occupancy keeps count + outstanding <= DEPTH.
    if (!ctl_d.outstanding && (fifo_count_next < CNT_W'(DEPTH))) begin
      ctl_d.outstanding = 1'b1;
      mem_addr_d        = fetch_addr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_q        <= '0;
      fetch_addr_q <= RESET_ADDR;
      mem_addr_q   <= RESET_ADDR;
    end else begin
      ctl_q        <= ctl_d;
      fetch_addr_q <= fetch_addr_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  assign mem_req     = ctl_q.outstanding;
  assign mem_addr    = mem_addr_q;
  assign instr_valid = (fifo_count != '0);
  assign instr       = fifo_head[ENT_W-1:ADDR_W];
  assign instr_addr  = fifo_head[ADDR_W-1:0];

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue: an inline SPI responder acks each request
// with 16'hA000 + address, and every step checks against hand-computed values.
module tb_instr_prefetch_queue;

  logic        clk;
  logic        rst;
  logic [15:0] instr;
  logic [15:0] instr_addr;
  logic        instr_valid;
  logic        advance;
  logic        redirect;
  logic [15:0] redirect_addr;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  instr_prefetch_queue dut (
    .clk           (clk),
    .rst           (rst),
    .instr         (instr),
    .instr_addr    (instr_addr),
    .instr_valid   (instr_valid),
    .advance       (advance),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver / checker tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (!mem_req && n < 20) begin
      tick();
      n++;
    end
    checks++;
    assert (mem_req === 1'b1) else begin
      errors++;
      $error("FAIL %s: observed no mem_req after %0d cycles expected mem_req=1", tag, n);
    end
  endtask

  // Responder: ack lands on the third clock edge after the request is seen.
  task automatic serve(input string tag, input logic [15:0] a);
    logic [15:0] d;
    wait_req({tag, "_req"});
    chk16({tag, "_addr"}, mem_addr, a);
    tick();
    tick();
    chk1({tag, "_req_hold"}, mem_req, 1'b1);
    chk16({tag, "_addr_hold"}, mem_addr, a);
    d         = 16'hA000 + a;
    mem_ack   = 1'b1;
    mem_rdata = d;
    tick();
    mem_ack   = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_w;
    rst           = 1'b1;
    advance       = 1'b0;
    redirect      = 1'b0;
    redirect_addr = 16'h0000;
    mem_ack       = 1'b0;
    mem_rdata     = 16'h0000;
    tick();
    tick();

    chk1 ("rst_valid",    instr_valid, 1'b0);
    chk1 ("rst_req",      mem_req,     1'b0);
    chk16("rst_mem_addr", mem_addr,    16'h0000);
    chk16("rst_instr",    instr,       16'h0000);
    chk16("rst_iaddr",    instr_addr,  16'h0000);
    rst = 1'b0;

    // 1: fill from reset
    wait_req("t1_first");
    chk1("t1_empty_before_ack", instr_valid, 1'b0);
    serve("t1_a0", 16'h0000);
    chk1 ("t1_latency_valid", instr_valid, 1'b1);
    chk16("t1_latency_instr", instr,       16'hA000);
    chk16("t1_latency_iaddr", instr_addr,  16'h0000);
    serve("t1_a1", 16'h0001);
    serve("t1_a2", 16'h0002);
    serve("t1_a3", 16'h0003);
    chk1("t1_full_no_req", mem_req, 1'b0);
    tick();
    tick();
    chk1 ("t1_full_still_no_req", mem_req, 1'b0);
    chk16("t1_head_unchanged",    instr,   16'hA000);

    // 2: drain with advance every cycle
    advance = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_w = 16'hA000 + 16'(i);
      chk16($sformatf("t2_instr%0d", i), instr,      exp_w);
      chk16($sformatf("t2_iaddr%0d", i), instr_addr, 16'(i));
      chk1 ($sformatf("t2_valid%0d", i), instr_valid, 1'b1);
      tick();
      if (i == 0) begin
        chk1 ("t2_req_after_pop",  mem_req,  1'b1);
        chk16("t2_addr_after_pop", mem_addr, 16'h0004);
      end
    end
    advance = 1'b0;
    chk1("t2_drained", instr_valid, 1'b0);

    // double redirect while the request to 4 is in flight: one ack is dropped
    redirect = 1'b1; redirect_addr = 16'h0030;
    tick();
    chk1 ("rr_req_held",  mem_req,  1'b1);
    chk16("rr_addr_held", mem_addr, 16'h0004);
    redirect_addr = 16'h0001;
    tick();
    redirect = 1'b0;
    mem_ack = 1'b1; mem_rdata = 16'hA004;
    tick();
    mem_ack = 1'b0;
    chk1 ("rr_drop_valid", instr_valid, 1'b0);
    chk1 ("rr_next_req",   mem_req,     1'b1);
    chk16("rr_next_addr",  mem_addr,    16'h0001);
    serve("rr_a1", 16'h0001);
    chk1 ("rr_head_valid", instr_valid, 1'b1);
    chk16("rr_head_instr", instr,       16'hA001);
    chk16("rr_next2_addr", mem_addr,    16'h0002);

    // 3: redirect to 0x0040 with the request to 0x0002 outstanding
    redirect = 1'b1; redirect_addr = 16'h0040; advance = 1'b1;
    tick();
    redirect = 1'b0; advance = 1'b0;
    chk1 ("t3_flush_valid", instr_valid, 1'b0);
    chk16("t3_addr_held",   mem_addr,    16'h0002);
    tick();
    mem_ack = 1'b1; mem_rdata = 16'hA002;
    tick();
    mem_ack = 1'b0;
    chk1 ("t3_dropped",   instr_valid, 1'b0);
    chk1 ("t3_req",       mem_req,     1'b1);
    chk16("t3_next_addr", mem_addr,    16'h0040);

    // 4: redirect to 0x0080 in the ack cycle of the 0x0040 request
    tick();
    tick();
    mem_ack = 1'b1; mem_rdata = 16'hA040;
    redirect = 1'b1; redirect_addr = 16'h0080;
    tick();
    mem_ack = 1'b0; redirect = 1'b0;
    chk1 ("t4_dropped",   instr_valid, 1'b0);
    chk1 ("t4_req",       mem_req,     1'b1);
    chk16("t4_next_addr", mem_addr,    16'h0080);
    serve("t4_a80", 16'h0080);
    chk1 ("t4_no_discard_valid", instr_valid, 1'b1);
    chk16("t4_instr",            instr,       16'hA080);
    chk16("t4_iaddr",            instr_addr,  16'h0080);
    chk16("t4_seq_addr",         mem_addr,    16'h0081);

    // 5: fetch address wrap at 16'hFFFF
    redirect = 1'b1; redirect_addr = 16'hFFFF;
    tick();
    redirect = 1'b0;
    mem_ack = 1'b1; mem_rdata = 16'hA081;
    tick();
    mem_ack = 1'b0;
    chk16("t5_req_ffff", mem_addr, 16'hFFFF);
    serve("t5_affff", 16'hFFFF);
    chk16("t5_instr", instr,      16'h9FFF);
    chk16("t5_iaddr", instr_addr, 16'hFFFF);
    chk16("t5_wrap",  mem_addr,   16'h0000);

    // 6: asynchronous reset with two entries queued and a request in flight
    serve("t6_a0", 16'h0000);
    chk1 ("t6_pre_valid", instr_valid, 1'b1);
    chk16("t6_pre_iaddr", instr_addr,  16'hFFFF);
    chk1 ("t6_pre_req",   mem_req,     1'b1);
    chk16("t6_pre_addr",  mem_addr,    16'h0001);
    #2;
    rst = 1'b1;
    #1;
    chk1 ("t6_async_valid", instr_valid, 1'b0);
    chk1 ("t6_async_req",   mem_req,     1'b0);
    chk16("t6_async_addr",  mem_addr,    16'h0000);
    chk16("t6_async_instr", instr,       16'h0000);
    tick();
    rst = 1'b0;
    serve("t6_restart", 16'h0000);
    chk1 ("t6_restart_valid", instr_valid, 1'b1);
    chk16("t6_restart_instr", instr,       16'hA000);
    chk16("t6_restart_next",  mem_addr,    16'h0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
